// File: rtl/wta_min_mask.sv
//------------------------------------------------------------------------------
// Module   : wta_min_mask
// Function : Streaming winner-take-all front end; running-minimum tie mask
//            over NDISP disparity costs per pixel, with output handshake.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module wta_min_mask #(
    parameter int COST_W = 12,
    parameter int NDISP  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [COST_W-1:0] cost_in,
    input  logic              cost_valid,
    input  logic              cost_last,
    output logic              cost_ready,
    output logic [31:0]       min_mask,
    output logic [COST_W-1:0] min_cost,
    output logic              mask_valid,
    input  logic              mask_ready,
    output logic              sync_err
);

    localparam logic [4:0] c_LAST_D = 5'(NDISP - 1);

    logic [4:0]        r_d;
    logic [COST_W-1:0] r_run_min;
    logic [31:0]       r_run_mask;
    logic [31:0]       r_min_mask;
    logic [COST_W-1:0] r_min_cost;
    logic              r_mask_valid;
    logic              r_sync_err;

    logic              w_at_last;
    logic              w_accept;
    logic              w_complete;
    logic [31:0]       w_bit;
    logic [COST_W-1:0] w_next_min;
    logic [31:0]       w_next_mask;

    assign w_at_last  = (r_d == c_LAST_D);
    // Only the final beat stalls; mid-pixel beats overlap a held result.
    assign cost_ready = !(w_at_last && r_mask_valid && !mask_ready);
    assign w_accept   = cost_valid && cost_ready;
    assign w_complete = w_accept && w_at_last;
    assign w_bit      = 32'd1 << r_d;

    always_comb begin
        w_next_min  = r_run_min;
        w_next_mask = r_run_mask;
        if (r_d == 5'd0 || cost_in < r_run_min) begin
            w_next_min  = cost_in;
            w_next_mask = w_bit;
        end else if (cost_in == r_run_min) begin
            w_next_mask = r_run_mask | w_bit;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_d          <= '0;
            r_run_min    <= '0;
            r_run_mask   <= '0;
            r_min_mask   <= '0;
            r_min_cost   <= '0;
            r_mask_valid <= 1'b0;
            r_sync_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                if (cost_last && !w_at_last) begin
                    // Early terminator: drop the partial pixel and resync.
                    r_sync_err <= 1'b1;
                    r_d        <= '0;
                end else begin
                    r_run_min  <= w_next_min;
                    r_run_mask <= w_next_mask;
                    if (w_at_last) begin
                        r_d <= '0;
                        if (!cost_last) begin
                            r_sync_err <= 1'b1;
                        end
                    end else begin
                        r_d <= r_d + 5'd1;
                    end
                end
            end

            if (w_complete) begin
                r_min_mask   <= w_next_mask;
                r_min_cost   <= w_next_min;
                r_mask_valid <= 1'b1;
            end else if (r_mask_valid && mask_ready) begin
                r_mask_valid <= 1'b0;
            end
        end
    end

    assign min_mask   = r_min_mask;
    assign min_cost   = r_min_cost;
    assign mask_valid = r_mask_valid;
    assign sync_err   = r_sync_err;

endmodule

`default_nettype wire

// File: tb/tb_wta_min_mask.sv
//------------------------------------------------------------------------------
// Module   : tb_wta_min_mask
// Function : Directed scoreboard bench for wta_min_mask.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_wta_min_mask;

    localparam int COST_W = 12;
    localparam int NDISP  = 32;

    logic              clk;
    logic              rst;
    logic [COST_W-1:0] cost_in;
    logic              cost_valid;
    logic              cost_last;
    logic              cost_ready;
    logic [31:0]       min_mask;
    logic [COST_W-1:0] min_cost;
    logic              mask_valid;
    logic              mask_ready;
    logic              sync_err;

    int n_checks = 0;
    int n_fails  = 0;

    typedef struct packed {
        logic [31:0]       mask;
        logic [COST_W-1:0] cost;
    } exp_t;

    exp_t              sb_q[$];
    logic [COST_W-1:0] pix[NDISP];

    wta_min_mask #(.COST_W(COST_W), .NDISP(NDISP)) dut (
        .clk        (clk),
        .rst        (rst),
        .cost_in    (cost_in),
        .cost_valid (cost_valid),
        .cost_last  (cost_last),
        .cost_ready (cost_ready),
        .min_mask   (min_mask),
        .min_cost   (min_cost),
        .mask_valid (mask_valid),
        .mask_ready (mask_ready),
        .sync_err   (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every handshaken result is matched against the scoreboard.
    always @(negedge clk) begin
        if (!rst && mask_valid && mask_ready) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fails++;
                $display("FAIL unexpected_output: got mask 0x%0h cost %0d with nothing expected",
                         min_mask, min_cost);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("out_mask", 64'(min_mask), 64'(e.mask));
                chk("out_cost", 64'(min_cost), 64'(e.cost));
            end
        end
    end

    task automatic drive(input logic [COST_W-1:0] c, input logic last);
        cost_in    = c;
        cost_last  = last;
        cost_valid = 1'b1;
    endtask

    task automatic wait_accept();
        int budget;
        budget = 200;
        forever begin
            @(negedge clk);
            if (cost_ready) break;
            budget--;
            if (budget == 0) begin
                chk("accept_timeout", 64'd1, 64'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
        cost_valid = 1'b0;
        cost_last  = 1'b0;
    endtask

    task automatic send_beat(input logic [COST_W-1:0] c, input logic last);
        drive(c, last);
        wait_accept();
    endtask

    task automatic send_pixel(input logic [31:0] em, input logic [COST_W-1:0] ec);
        for (int d = 0; d < NDISP; d++) begin
            if (d == NDISP - 1) sb_q.push_back('{mask: em, cost: ec});
            send_beat(pix[d], d == NDISP - 1);
        end
    endtask

    initial begin
        rst        = 1'b1;
        cost_in    = '0;
        cost_valid = 1'b0;
        cost_last  = 1'b0;
        mask_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_mask",  64'(min_mask),   64'd0);
        chk("rst_cost",  64'(min_cost),   64'd0);
        chk("rst_valid", 64'(mask_valid), 64'd0);
        chk("rst_err",   64'(sync_err),   64'd0);
        chk("rst_ready", 64'(cost_ready), 64'd1);
        rst = 1'b0;
        @(posedge clk); #1;

        // Unique minimum at disparity 0, with latency check.
        for (int d = 0; d < NDISP; d++) pix[d] = COST_W'(100 + d);
        send_pixel(32'h0000_0001, 12'd100);
        chk("lat1_valid", 64'(mask_valid), 64'd1);
        chk("lat1_mask",  64'(min_mask),   64'h1);
        repeat (2) @(posedge clk); #1;

        // Unique minimum at 17.
        for (int d = 0; d < NDISP; d++) pix[d] = 12'd500;
        pix[17] = 12'd42;
        send_pixel(32'h0002_0000, 12'd42);
        repeat (2) @(posedge clk); #1;

        // Ties at 3, 9, 31 with a near-miss at 20.
        for (int d = 0; d < NDISP; d++) pix[d] = 12'd900;
        pix[3] = 12'd7; pix[9] = 12'd7; pix[31] = 12'd7; pix[20] = 12'd8;
        send_pixel(32'h8000_0208, 12'd7);
        repeat (2) @(posedge clk); #1;

        // Backpressure: A held while B streams, B's last beat stalls.
        mask_ready = 1'b0;
        for (int d = 0; d < NDISP; d++) pix[d] = COST_W'(200 + (31 - d));
        send_pixel(32'h8000_0000, 12'd200);
        for (int d = 0; d < NDISP - 1; d++) send_beat(12'hFFF, 1'b0);
        sb_q.push_back('{mask: 32'hFFFF_FFFF, cost: 12'hFFF});
        drive(12'hFFF, 1'b1);
        repeat (5) begin
            @(negedge clk);
            chk("bp_ready_low", 64'(cost_ready), 64'd0);
            chk("bp_hold_vld",  64'(mask_valid), 64'd1);
            chk("bp_hold_mask", 64'(min_mask),   64'h8000_0000);
            chk("bp_hold_cost", 64'(min_cost),   64'd200);
        end
        @(posedge clk); #1;
        mask_ready = 1'b1;
        wait_accept();
        chk("bp_b_valid", 64'(mask_valid), 64'd1);
        chk("bp_b_mask",  64'(min_mask),   64'hFFFF_FFFF);
        repeat (2) @(posedge clk); #1;

        // Framing error: early cost_last at disparity 12.
        for (int d = 0; d < 13; d++) send_beat(12'd1, d == 12);
        chk("fr_err",   64'(sync_err),   64'd1);
        chk("fr_valid", 64'(mask_valid), 64'd0);
        repeat (2) @(negedge clk);
        chk("fr_valid2", 64'(mask_valid), 64'd0);
        @(posedge clk); #1;
        for (int d = 0; d < NDISP; d++) pix[d] = COST_W'(20 + (d * 7) % 13);
        send_pixel(32'h0400_2001, 12'd20);
        chk("fr_err_sticky", 64'(sync_err), 64'd1);
        repeat (2) @(posedge clk); #1;

        // Reset mid-pixel.
        for (int d = 0; d < 10; d++) send_beat(12'd0, 1'b0);
        rst = 1'b1;
        #1;
        chk("mr_mask",  64'(min_mask),   64'd0);
        chk("mr_cost",  64'(min_cost),   64'd0);
        chk("mr_valid", 64'(mask_valid), 64'd0);
        chk("mr_err",   64'(sync_err),   64'd0);
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk); #1;
        for (int d = 0; d < NDISP; d++) pix[d] = 12'd1000;
        pix[5] = 12'd3;
        send_pixel(32'h0000_0020, 12'd3);
        chk("mr_new_mask", 64'(min_mask), 64'h20);

        begin
            int budget;
            budget = 100;
            while (sb_q.size() != 0 && budget > 0) begin
                @(posedge clk);
                budget--;
            end
            chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        end
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/wta_min_mask.md
Name: wta_min_mask

Overview:
Streaming winner-take-all front end of the DisparityMap stage. Consumes one aggregated SGM cost per cycle for disparities 0..NDISP-1 of a pixel, tracks the running minimum, and produces a 32-bit mask of every disparity whose cost equals the minimum. The registered mask feeds the 32-bit priority encoder directly downstream, which resolves the mask to a 5-bit disparity index (highest set bit wins).

Parameters:
COST_W, 12, width of one aggregated cost
NDISP, 32, disparities per pixel; legal range 2..32; mask bits at or above NDISP are always 0

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous active-high reset
cost_in  in  COST_W  aggregated cost for current disparity
cost_valid  in  1  cost_in valid this cycle
cost_last  in  1  marks the beat for disparity NDISP-1; qualified by cost_valid
cost_ready  out  1  block accepts a beat when cost_valid && cost_ready
min_mask  out  32  bit d set iff cost(d) == pixel minimum
min_cost  out  COST_W  pixel minimum cost
mask_valid  out  1  min_mask/min_cost valid
mask_ready  in  1  downstream accepts when mask_valid && mask_ready
sync_err  out  1  sticky framing error flag

Behaviour:
- Reset values (asynchronous, on rst high): disparity counter d=0, run_min=0, run_mask=0, min_mask=0, min_cost=0, mask_valid=0, sync_err=0. Reset mid-pixel discards the partial pixel; the next accepted beat is disparity 0.
- Accumulate (accepted beat, d = counter):
  - d==0: run_min<=cost_in; run_mask<=1<<0.
  - d>0, cost_in<run_min (unsigned): run_min<=cost_in; run_mask<=1<<d.
  - d>0, cost_in==run_min: run_mask<=run_mask | (1<<d).
  - d>0, cost_in>run_min: no change.
- Counter: increments on every accepted beat; wraps to 0 after d==NDISP-1.
- Completion: the accepted beat at d==NDISP-1 with cost_last=1 loads min_mask/min_cost with the final values, including that beat's own compare result. mask_valid=1 on the next cycle (latency 1 cycle from last beat). No combinational path from cost_in to outputs.
- Output handshake: mask_valid, min_mask, and min_cost hold stable until mask_valid && mask_ready.
  - If a new completion coincides with a drain, the new result loads and mask_valid stays 1.
  - A drain without a new completion clears mask_valid; min_mask and min_cost keep their last values.
- Backpressure: cost_ready = !(d==NDISP-1 && mask_valid && !mask_ready). Mid-pixel beats are always accepted while an output is held, giving one pixel of overlap.
- Framing checks:
  - Accepted beat with cost_last=1 and d!=NDISP-1: set sync_err, discard the partial pixel, reset d to 0, produce no output.
  - Accepted beat at d==NDISP-1 with cost_last=0: set sync_err, still complete the pixel normally.
  - sync_err clears only on rst.
- Edge cases:
  - All costs equal (including all-ones): mask has bits 0..NDISP-1 set, and min_cost equals that value.
  - cost_valid low: the counter holds, and gaps are allowed at any disparity.

Test Plan:
- Reset and unique minimum at 0. NDISP=32, COST_W=12, mask_ready=1, costs 100+d for d=0..31, back-to-back -> one cycle after the last beat, mask_valid=1, min_mask=0x00000001, min_cost=100.
- Unique minimum at 17. Costs 500 except cost(17)=42 -> min_mask=0x00020000, min_cost=42; downstream encoder gives 17.
- Ties. Costs 900 except cost(3)=cost(9)=cost(31)=7, with cost(20)=8 arriving before 31 -> min_mask=0x80000208, min_cost=7.
- Backpressure. mask_ready=0 after pixel A completes; stream pixel B -> beats 0..30 accepted, cost_ready=0 at d=31, and the A result holds stable. Raise mask_ready -> A drains, B's beat 31 is accepted, and the B result is valid next cycle.
- Framing error. cost_last=1 on disparity 12 -> sync_err=1, no mask_valid pulse; a following clean 32-beat pixel produces the correct mask, and sync_err stays 1.
- Reset mid-pixel. Assert rst after 10 beats, then send a full pixel with minimum at 5 -> all outputs go to 0 during reset, then min_mask=0x00000020.
